// File: rtl/doppler_frame_ctrl_pkg.sv
// Shared types and defaults for the Doppler frame sequencer.
// Holds the write/read FSM encodings, the default frame geometry and
// a small helper that turns a bank index into a one-hot bank_full mask.
package doppler_frame_ctrl_pkg;

    // Default frame geometry: 256-sample frames, 8-bit buffer address.
    localparam int DEFAULT_FFT_LEN     = 256;
    localparam int DEFAULT_ADDR_W      = 8;
    localparam int DEFAULT_FRAME_CNT_W = 16;

    // Write side: idle (disabled), armed (waiting for a valid edge), filling.
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ARM  = 2'd1,
        W_FILL = 2'd2
    } w_state_t;

    // Read side: waiting for a full bank, or FFT running on fft_bank.
    typedef enum logic {
        R_IDLE = 1'b0,
        R_RUN  = 1'b1
    } r_state_t;

    // One-hot mask selecting a single ping-pong bank in bank_full.
    function automatic logic [1:0] bank_mask(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/doppler_frame_ctrl_start_gen.sv
// Frame-start detector: produces a pulse on the rising edge of valid_Ff.
// The delayed copy is cleared by reset, so a valid_Ff already high when
// reset releases counts as an edge on the first cycle.
module doppler_frame_ctrl_start_gen (
    input  logic fast_clk,
    input  logic reset,
    input  logic valid_Ff,
    output logic start
);

    logic valid_d1;

    // One-cycle delayed copy of valid_Ff for edge detection.
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            valid_d1 <= 1'b0;
        end else begin
            valid_d1 <= valid_Ff;
        end
    end

    assign start = valid_Ff & ~valid_d1;

endmodule

// File: rtl/doppler_frame_ctrl.sv
// Frame sequencer between the Doppler sample stream and the FFT engine.
// The write FSM aligns each frame to a rising edge of valid_Ff and packs
// FFT_LEN samples into one half of a ping-pong buffer; the read FSM
// launches the FFT on each full bank and counts completed spectra.
// A frame start that finds its target bank still full is dropped and
// latches the sticky overflow flag.
module doppler_frame_ctrl
    import doppler_frame_ctrl_pkg::*;
#(
    parameter int FFT_LEN     = DEFAULT_FFT_LEN,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int FRAME_CNT_W = DEFAULT_FRAME_CNT_W
) (
    input  logic                   fast_clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   valid_Ff,
    input  logic                   fft_ready,
    input  logic                   fft_done,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic                   wr_bank,
    output logic                   fft_start,
    output logic                   fft_bank,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overflow,
    output logic                   busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_LEN - 1);

    w_state_t          w_state;
    w_state_t          w_state_next;
    r_state_t          r_state;
    r_state_t          r_state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              wr_bank_next;
    logic              fft_bank_next;
    logic [1:0]        bank_full;
    logic [1:0]        set_full;
    logic [1:0]        clr_full;
    logic              overflow_set;
    logic              frame_inc;
    logic              start;

    doppler_frame_ctrl_start_gen start_gen (
        .fast_clk (fast_clk),
        .reset    (reset),
        .valid_Ff (valid_Ff),
        .start    (start)
    );

    // Write FSM next state: enable low aborts any partial frame, otherwise
    // arm on an edge into an empty bank and fill until the last address.
    always_comb begin
        w_state_next = w_state;
        cnt_next     = cnt;
        wr_bank_next = wr_bank;
        wr_en        = 1'b0;
        wr_addr      = '0;
        set_full     = 2'b00;
        overflow_set = 1'b0;
        if (!enable) begin
            w_state_next = W_IDLE;
            cnt_next     = '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    w_state_next = W_ARM;
                end
                W_ARM: begin
                    if (start) begin
                        if (bank_full[wr_bank]) begin
                            overflow_set = 1'b1;
                        end else begin
                            wr_en        = 1'b1;
                            wr_addr      = '0;
                            cnt_next     = ADDR_W'(1);
                            w_state_next = W_FILL;
                        end
                    end
                end
                W_FILL: begin
                    wr_addr = cnt;
                    if (valid_Ff) begin
                        wr_en = 1'b1;
                        if (cnt == LAST_ADDR) begin
                            set_full     = bank_mask(wr_bank);
                            wr_bank_next = ~wr_bank;
                            cnt_next     = '0;
                            w_state_next = W_ARM;
                        end else begin
                            cnt_next = cnt + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_next = W_IDLE;
                    cnt_next     = '0;
                end
            endcase
        end
    end

    // Read FSM next state: launch on a full bank when the engine is ready,
    // then release the bank and move to the other one when the FFT finishes.
    always_comb begin
        r_state_next  = r_state;
        fft_bank_next = fft_bank;
        fft_start     = 1'b0;
        clr_full      = 2'b00;
        frame_inc     = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (bank_full[fft_bank] && fft_ready) begin
                    fft_start    = 1'b1;
                    r_state_next = R_RUN;
                end
            end
            R_RUN: begin
                if (fft_done) begin
                    clr_full      = bank_mask(fft_bank);
                    fft_bank_next = ~fft_bank;
                    frame_inc     = 1'b1;
                    r_state_next  = R_IDLE;
                end
            end
            default: begin
                r_state_next = R_IDLE;
            end
        endcase
    end

    // Write-side state, fill counter and fill bank.
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            cnt     <= '0;
            wr_bank <= 1'b0;
        end else begin
            w_state <= w_state_next;
            cnt     <= cnt_next;
            wr_bank <= wr_bank_next;
        end
    end

    // Read-side state, FFT bank pointer and completed-spectrum counter.
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            r_state   <= R_IDLE;
            fft_bank  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            r_state  <= r_state_next;
            fft_bank <= fft_bank_next;
            if (frame_inc) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // Bank occupancy: a set and a clear in the same cycle always target
    // different banks, so both are applied together.
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full & ~clr_full) | set_full;
        end
    end

    // Sticky overflow: set when a frame start is dropped, cleared only by reset.
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end
    end

    assign busy = (w_state == W_FILL) | (r_state == R_RUN) | (|bank_full);

endmodule

// File: tb/tb_doppler_frame_ctrl.sv
// Bench for doppler_frame_ctrl with 8-sample frames.
// Expected buffer writes and FFT launches are queued as stimulus is
// issued; a monitor pops and compares them whenever the DUT strobes.
module tb_doppler_frame_ctrl;

    localparam int FFT_LEN     = 8;
    localparam int ADDR_W      = 3;
    localparam int FRAME_CNT_W = 16;

    logic                   fast_clk;
    logic                   reset;
    logic                   enable;
    logic                   valid_Ff;
    logic                   fft_ready;
    logic                   fft_done;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic                   wr_bank;
    logic                   fft_start;
    logic                   fft_bank;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   overflow;
    logic                   busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [ADDR_W:0] exp_wr_q[$];
    logic            exp_start_q[$];

    doppler_frame_ctrl #(
        .FFT_LEN     (FFT_LEN),
        .ADDR_W      (ADDR_W),
        .FRAME_CNT_W (FRAME_CNT_W)
    ) dut (
        .fast_clk  (fast_clk),
        .reset     (reset),
        .enable    (enable),
        .valid_Ff  (valid_Ff),
        .fft_ready (fft_ready),
        .fft_done  (fft_done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_bank   (wr_bank),
        .fft_start (fft_start),
        .fft_bank  (fft_bank),
        .frame_cnt (frame_cnt),
        .overflow  (overflow),
        .busy      (busy)
    );

    // Free-running 100 MHz clock.
    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // Queue the writes of one frame: addresses 0..n-1 in the given bank.
    task automatic expect_writes(input logic bank, input int n);
        for (int i = 0; i < n; i++) begin
            exp_wr_q.push_back({bank, ADDR_W'(i)});
        end
    endtask

    // Hold valid_Ff at the given level for a number of cycles.
    task automatic apply_stimulus(input logic v, input int cycles);
        valid_Ff = v;
        repeat (cycles) tick();
    endtask

    // Caller is in an R_RUN cycle; deliver a one-cycle fft_done.
    task automatic pulse_done();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    // Monitor: every write strobe and FFT launch must match the next expectation.
    always @(negedge fast_clk) begin
        if (wr_en) begin
            vectors++;
            if (exp_wr_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL wr_unexpected: got bank %0d addr %0d, required no write",
                         wr_bank, wr_addr);
            end else begin
                logic [ADDR_W:0] e;
                e = exp_wr_q.pop_front();
                if ({wr_bank, wr_addr} !== e) begin
                    miscompares++;
                    $display("[TB] FAIL wr_seq: got bank %0d addr %0d, required bank %0d addr %0d",
                             wr_bank, wr_addr, e[ADDR_W], e[ADDR_W-1:0]);
                end
            end
        end
        if (fft_start) begin
            vectors++;
            if (exp_start_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL start_unexpected: got fft_start bank %0d, required none",
                         fft_bank);
            end else begin
                logic eb;
                eb = exp_start_q.pop_front();
                if (fft_bank !== eb) begin
                    miscompares++;
                    $display("[TB] FAIL start_bank: got %0d, required %0d", fft_bank, eb);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        valid_Ff  = 1'b0;
        fft_ready = 1'b0;
        fft_done  = 1'b0;
        repeat (3) tick();
        @(negedge fast_clk);
        check_output("rst_wr_en", wr_en, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_frame_cnt", frame_cnt, 0);

        // Reset in the middle of a fill, five samples in.
        $display("[TB] reset mid-fill");
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        expect_writes(1'b0, 5);
        apply_stimulus(1'b1, 5);
        valid_Ff = 1'b0;
        reset    = 1'b1;
        @(negedge fast_clk);
        check_output("fill_busy", busy, 1);
        tick();
        @(negedge fast_clk);
        check_output("r1_wr_en", wr_en, 0);
        check_output("r1_wr_addr", wr_addr, 0);
        check_output("r1_wr_bank", wr_bank, 0);
        check_output("r1_fft_start", fft_start, 0);
        check_output("r1_fft_bank", fft_bank, 0);
        check_output("r1_frame_cnt", frame_cnt, 0);
        check_output("r1_overflow", overflow, 0);
        check_output("r1_busy", busy, 0);
        tick();
        reset = 1'b0;
        tick();

        // Single frame with the FFT engine ready.
        $display("[TB] single frame");
        fft_ready = 1'b1;
        expect_writes(1'b0, 8);
        exp_start_q.push_back(1'b0);
        apply_stimulus(1'b1, 8);
        valid_Ff = 1'b0;
        @(negedge fast_clk);
        check_output("lat_fft_start", fft_start, 1);
        check_output("lat_fft_bank", fft_bank, 0);
        check_output("lat_wr_bank", wr_bank, 1);
        tick();
        @(negedge fast_clk);
        check_output("run_fft_start", fft_start, 0);
        tick();
        pulse_done();
        @(negedge fast_clk);
        check_output("f1_frame_cnt", frame_cnt, 1);
        check_output("f1_fft_bank", fft_bank, 1);
        check_output("f1_busy", busy, 0);
        tick();

        // valid_Ff held for two frame lengths: only one frame is written.
        $display("[TB] long valid");
        expect_writes(1'b1, 8);
        exp_start_q.push_back(1'b1);
        apply_stimulus(1'b1, 16);
        valid_Ff = 1'b0;
        pulse_done();
        @(negedge fast_clk);
        check_output("f2_frame_cnt", frame_cnt, 2);
        check_output("f2_fft_bank", fft_bank, 0);
        check_output("f2_wr_bank", wr_bank, 0);
        tick();

        // Engine stalled: two banks fill, the third frame overflows.
        $display("[TB] overflow");
        fft_ready = 1'b0;
        expect_writes(1'b0, 8);
        expect_writes(1'b1, 8);
        apply_stimulus(1'b1, 8);
        apply_stimulus(1'b0, 1);
        apply_stimulus(1'b1, 8);
        valid_Ff = 1'b0;
        @(negedge fast_clk);
        check_output("pre_overflow", overflow, 0);
        check_output("full_busy", busy, 1);
        tick();
        apply_stimulus(1'b1, 8);
        valid_Ff = 1'b0;
        @(negedge fast_clk);
        check_output("ovf_set", overflow, 1);
        check_output("ovf_wr_bank", wr_bank, 0);
        tick();
        exp_start_q.push_back(1'b0);
        exp_start_q.push_back(1'b1);
        fft_ready = 1'b1;
        tick();
        pulse_done();
        tick();
        pulse_done();
        @(negedge fast_clk);
        check_output("drain_frame_cnt", frame_cnt, 4);
        check_output("drain_busy", busy, 0);
        tick();
        expect_writes(1'b0, 8);
        exp_start_q.push_back(1'b0);
        apply_stimulus(1'b1, 8);
        valid_Ff = 1'b0;
        tick();
        pulse_done();
        @(negedge fast_clk);
        check_output("resume_frame_cnt", frame_cnt, 5);
        check_output("ovf_sticky", overflow, 1);
        tick();

        // Alternating valid_Ff: the address advances only on valid cycles.
        $display("[TB] gapped valid");
        expect_writes(1'b1, 8);
        exp_start_q.push_back(1'b1);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1);
            apply_stimulus(1'b0, 1);
        end
        pulse_done();
        @(negedge fast_clk);
        check_output("gap_frame_cnt", frame_cnt, 6);
        check_output("gap_fft_bank", fft_bank, 0);
        check_output("gap_wr_bank", wr_bank, 0);
        tick();

        // Enable dropped three samples in: partial frame is discarded.
        $display("[TB] enable abort");
        expect_writes(1'b0, 3);
        apply_stimulus(1'b1, 3);
        valid_Ff = 1'b0;
        enable   = 1'b0;
        tick();
        valid_Ff = 1'b1;
        @(negedge fast_clk);
        check_output("abort_wr_en", wr_en, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_wr_bank", wr_bank, 0);
        tick();
        tick();
        valid_Ff = 1'b0;
        enable   = 1'b1;
        tick();
        expect_writes(1'b0, 8);
        exp_start_q.push_back(1'b0);
        apply_stimulus(1'b1, 8);
        valid_Ff = 1'b0;
        tick();
        pulse_done();
        @(negedge fast_clk);
        check_output("refill_frame_cnt", frame_cnt, 7);
        check_output("refill_fft_bank", fft_bank, 1);
        check_output("refill_wr_bank", wr_bank, 1);
        repeat (3) tick();

        check_output("pending_writes", exp_wr_q.size(), 0);
        check_output("pending_starts", exp_start_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
